// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, error-response states and byte-lane helpers
// for the master and the FIR accelerator slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    NORMAL,
    ERR1,
    ERR2
  } err_state_t;

  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;

  // Right-justified command data onto the byte lane selected by the address LSB.
  function automatic logic [15:0] place_wdata(input logic size, input logic lane,
                                              input logic [15:0] wdata);
    if (size == HSIZE_HALF) return wdata;
    return lane ? {wdata[7:0], 8'h00} : {8'h00, wdata[7:0]};
  endfunction

  function automatic logic [15:0] pick_rdata(input logic size, input logic lane,
                                             input logic [15:0] rdata);
    if (size == HSIZE_HALF) return rdata;
    return lane ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands become single NONSEQ transfers with
// overlapped address/data phases and a registered per-transfer response strobe.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic              hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef struct packed {
    logic              valid;
    logic              write;
    logic              size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } aph_t;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic              size;
    logic              lane;
    logic [DATA_W-1:0] wdata;
  } dph_t;

  aph_t       aph_q, aph_d;
  dph_t       dph_q, dph_d;
  err_state_t state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic present, aph_adv, done, accept;

  always_comb begin
    state_d     = state_q;
    aph_d       = aph_q;
    dph_d       = dph_q;
    // A retained address phase is withheld while the slave finishes its ERROR.
    present     = aph_q.valid && (state_q != ERR1);
    aph_adv     = present && hready;
    done        = dph_q.valid && hready;
    cmd_ready   = (state_q == NORMAL) && (!aph_q.valid || hready) && !hresp;
    accept      = cmd_valid && cmd_ready;

    if (done) dph_d = '0;
    if (aph_adv) begin
      dph_d.valid = 1'b1;
      dph_d.write = aph_q.write;
      dph_d.size  = aph_q.size;
      dph_d.lane  = aph_q.addr[0];
      dph_d.wdata = aph_q.wdata;
      aph_d       = '0;
    end
    if (accept) begin
      aph_d.valid = 1'b1;
      aph_d.write = cmd_write;
      aph_d.size  = cmd_size;
      aph_d.addr  = cmd_addr;
      if (cmd_size == HSIZE_HALF) aph_d.addr[0] = 1'b0;
      aph_d.wdata = place_wdata(cmd_size, cmd_addr[0], cmd_wdata);
    end

    unique case (state_q)
      NORMAL:  if (dph_q.valid && hresp && !hready) state_d = ERR1;
      ERR1:    if (hready) state_d = ERR2;
      ERR2:    state_d = NORMAL;
      default: state_d = NORMAL;
    endcase

    rsp_valid_d = done;
    rsp_err_d   = done && hresp;
    rsp_rdata_d = (done && !dph_q.write) ? pick_rdata(dph_q.size, dph_q.lane, hrdata) : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= NORMAL;
      aph_q       <= '0;
      dph_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aph_q       <= aph_d;
      dph_q       <= dph_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign htrans    = present ? NONSEQ : IDLE;
  assign hsel      = htrans[1];
  assign haddr     = aph_q.addr;
  assign hwrite    = aph_q.write;
  assign hsize     = aph_q.size;
  assign hwdata    = dph_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: directed protocol steps plus a random command
// stream, checked against a byte-memory reference model and a bus slave model.
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_size;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        hsel, hwrite, hsize;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [15:0] hwdata, hrdata;
  logic        hready, hresp;

  ahb_lite_master #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rsp_count = 0;
  int acc_count = 0;
  int flushed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: byte memory behind a zero-wait AHB-Lite data phase.
  logic [7:0] smem [16];
  logic       dp_valid, dp_write, dp_size;
  logic [3:0] dp_addr;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid <= 1'b0;
    end else if (hready) begin
      if (dp_valid && dp_write && !hresp) begin
        if (dp_size) begin
          smem[{dp_addr[3:1], 1'b0}] <= hwdata[7:0];
          smem[{dp_addr[3:1], 1'b1}] <= hwdata[15:8];
        end else begin
          smem[dp_addr] <= dp_addr[0] ? hwdata[15:8] : hwdata[7:0];
        end
      end
      dp_valid <= hsel && (htrans == 2'b10);
      dp_addr  <= haddr;
      dp_write <= hwrite;
      dp_size  <= hsize;
    end
  end

  assign hrdata = (dp_valid && !dp_write) ?
                  {smem[{dp_addr[3:1], 1'b1}], smem[{dp_addr[3:1], 1'b0}]} : 16'h0;

  // Reference model: in-order completions against a plain byte memory.
  typedef struct {
    logic        w;
    logic        s;
    logic [3:0]  a;
    logic [15:0] d;
    logic        e;
  } cmd_t;

  cmd_t       expq[$];
  logic [7:0] rmem [16];
  logic       next_err = 1'b0;

  always @(negedge clk) begin : monitor
    cmd_t        c;
    logic [15:0] exp_rd;
    logic [3:0]  ah;
    if (n_rst && rsp_valid) begin
      rsp_count++;
      if (expq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        c  = expq.pop_front();
        ah = {c.a[3:1], 1'b0};
        if (c.w) exp_rd = 16'h0;
        else     exp_rd = c.s ? {rmem[ah + 4'd1], rmem[ah]} : {8'h00, rmem[c.a]};
        chk("rsp_err", 32'(rsp_err), 32'(c.e));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        if (c.w && !c.e) begin
          if (c.s) begin
            rmem[ah]        = c.d[7:0];
            rmem[ah + 4'd1] = c.d[15:8];
          end else begin
            rmem[c.a] = c.d[7:0];
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic w, input logic s, input logic [3:0] a,
                      input logic [15:0] d, input logic rdy, input logic resp,
                      output logic acc);
    @(negedge clk);
    cmd_valid = v; cmd_write = w; cmd_size = s; cmd_addr = a; cmd_wdata = d;
    hready = rdy; hresp = resp;
    #4;
    acc = v && cmd_ready;
    if (acc) begin
      expq.push_back(cmd_t'{w, s, a, d, next_err});
      next_err = 1'b0;
      acc_count++;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic        acc, pv, pw, ps;
    logic [3:0]  pa;
    logic [15:0] pd;
    int          r0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 8'h00;
      rmem[i] = 8'h00;
    end
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 1'b0;
    cmd_addr = 4'h0; cmd_wdata = 16'h0; hready = 1'b1; hresp = 1'b0;

    // Reset state
    #13;
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", 32'(haddr), 32'd0);
    chk("rst_hwdata", 32'(hwdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Halfword write 0x1234 @4, then halfword read @4
    r0 = rsp_count;
    step(1'b1, 1'b1, 1'b1, 4'd4, 16'h1234, 1'b1, 1'b0, acc);
    chk("t1_wr_accept", 32'(acc), 32'd1);
    step(1'b1, 1'b0, 1'b1, 4'd4, 16'h0, 1'b1, 1'b0, acc);
    chk("t1_rd_accept", 32'(acc), 32'd1);
    chk("t1_htrans", 32'(htrans), 32'd2);
    chk("t1_hsel", 32'(hsel), 32'd1);
    chk("t1_haddr", 32'(haddr), 32'd4);
    chk("t1_hwrite", 32'(hwrite), 32'd1);
    chk("t1_hsize", 32'(hsize), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t1_hwdata", 32'(hwdata), 32'h1234);
    chk("t1_rd_hwrite", 32'(hwrite), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t1_wr_rsp", 32'(rsp_valid), 32'd1);
    chk("t1_wr_err", 32'(rsp_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t1_rd_rsp", 32'(rsp_valid), 32'd1);
    chk("t1_rd_data", 32'(rsp_rdata), 32'h1234);
    idle(2);
    chk("t1_rsp_pulses", 32'(rsp_count - r0), 32'd2);

    // Byte write 0xAB @7, byte read @7, halfword write at odd address
    step(1'b1, 1'b1, 1'b0, 4'd7, 16'h55AB, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 4'd7, 16'h0, 1'b1, 1'b0, acc);
    chk("t2_hsize", 32'(hsize), 32'd0);
    chk("t2_haddr", 32'(haddr), 32'd7);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t2_hwdata", 32'(hwdata), 32'hAB00);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 4'd9, 16'h5678, 1'b1, 1'b0, acc);
    chk("t2_rd_byte", 32'(rsp_rdata), 32'h00AB);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t2_half_odd_haddr", 32'(haddr), 32'd8);
    idle(3);

    // Four back-to-back writes with hready held high
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 1'b1, 1'b1, 4'(2 * i), 16'($urandom), 1'b1, 1'b0, acc);
      if (i < 4) chk("t3_cmd_ready", 32'(acc), 32'd1);
      if (i >= 1 && i <= 4) begin
        chk("t3_nonseq", 32'(htrans), 32'd2);
        chk("t3_haddr", 32'(haddr), 32'(2 * (i - 1)));
      end
      if (i >= 3 && i <= 6) chk("t3_rsp_run", 32'(rsp_valid), 32'd1);
      if (i == 7) chk("t3_rsp_end", 32'(rsp_valid), 32'd0);
    end

    // Data phase stalled three cycles with a second transfer waiting
    step(1'b1, 1'b1, 1'b1, 4'd2, 16'hBEEF, 1'b1, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 4'd12, 16'h0F0F, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, acc);
      chk("t4_hwdata_frozen", 32'(hwdata), 32'hBEEF);
      chk("t4_haddr_frozen", 32'(haddr), 32'd12);
      chk("t4_htrans_frozen", 32'(htrans), 32'd2);
      chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t4_not_ready", 32'(cmd_ready), 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t4_rsp_delayed", 32'(rsp_valid), 32'd1);
    chk("t4_next_hwdata", 32'(hwdata), 32'h0F0F);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t4_rsp_second", 32'(rsp_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t4_rsp_done", 32'(rsp_valid), 32'd0);

    // Two-cycle ERROR on write @0 with write @6 queued behind it
    next_err = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'd0, 16'h1111, 1'b1, 1'b0, acc);
    chk("t5_accept0", 32'(acc), 32'd1);
    step(1'b1, 1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 1'b0, acc);
    chk("t5_accept6", 32'(acc), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, acc);
    chk("t5_err_a_haddr", 32'(haddr), 32'd6);
    chk("t5_err_a_ready", 32'(cmd_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, acc);
    chk("t5_err1_idle", 32'(htrans), 32'd0);
    chk("t5_err1_hsel", 32'(hsel), 32'd0);
    chk("t5_err1_ready", 32'(cmd_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t5_reissue", 32'(htrans), 32'd2);
    chk("t5_reissue_addr", 32'(haddr), 32'd6);
    chk("t5_err_rsp", 32'(rsp_err), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t5_hwdata6", 32'(hwdata), 32'h6666);
    chk("t5_no_dup_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_ready_back", 32'(cmd_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t5_ok_rsp", 32'(rsp_valid), 32'd1);
    chk("t5_ok_err", 32'(rsp_err), 32'd0);

    // Single-cycle ERROR with no preceding stall
    next_err = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'd14, 16'h7777, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, acc);
    chk("t6_ready_low", 32'(cmd_ready), 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, acc);
    chk("t6_err_rsp", 32'(rsp_err), 32'd1);
    chk("t6_still_normal", 32'(cmd_ready), 32'd1);
    idle(2);

    // Reset asserted during a data phase
    step(1'b1, 1'b1, 1'b1, 4'd10, 16'hCAFE, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 1'b1, 4'd2, 16'h0, 1'b1, 1'b0, acc);
    @(negedge clk);
    n_rst = 1'b0;
    cmd_valid = 1'b0;
    flushed += expq.size();
    expq.delete();
    #4;
    chk("t7_htrans", 32'(htrans), 32'd0);
    chk("t7_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #4;
    chk("t7_ready", 32'(cmd_ready), 32'd1);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 4'd10, 16'h0, 1'b1, 1'b0, acc);
    idle(4);

    // Random commands under random wait states
    pv = 1'b0; pw = 1'b0; ps = 1'b0; pa = 4'h0; pd = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(3) != 0) begin
        pv = 1'b1;
        pw = 1'($urandom_range(1));
        ps = 1'($urandom_range(1));
        pa = 4'($urandom_range(15));
        pd = 16'($urandom);
      end
      step(pv, pw, ps, pa, pd, $urandom_range(3) != 0, 1'b0, acc);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 50 && expq.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    chk("rsp_total", 32'(rsp_count + flushed), 32'(acc_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
